// File: rtl/perceptron_uart_sequencer.sv
`default_nettype none
// perceptron_uart_sequencer: host command parser feeding weighted_sum_top (rev 1.0).
// Loads x/w holding registers from UART bytes and returns the sum MSB byte first.
module perceptron_uart_sequencer #(
  parameter int N       = 8,
  parameter int W       = 18,
  parameter int SUM_W   = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_present,
  output logic             rx_read,
  output logic [7:0]       tx_data,
  output logic             tx_write,
  input  logic             tx_full,
  output logic [W*N-1:0]   x_flat,
  output logic [W*N-1:0]   w_flat,
  output logic             ws_start,
  input  logic             ws_done,
  input  logic [SUM_W-1:0] ws_sum,
  output logic             busy
);
  localparam int B      = (W + 7) / 8;
  localparam int ACC_W  = B * 8;
  localparam int NVAL   = 2 * N;
  localparam int NBYTES = SUM_W / 8;
  localparam int BCW    = (B > 1) ? $clog2(B) : 1;
  localparam int VCW    = $clog2(NVAL);
  localparam int TCW    = $clog2(TIMEOUT);
  localparam int SCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_TMO  = 8'h54;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [BCW-1:0]   bcnt;
  logic [VCW-1:0]   vcnt;
  logic [TCW-1:0]   tcnt;
  logic [SCW-1:0]   scnt;
  logic [SUM_W-1:0] sum_sh;
  logic [7:0]       resp;
  logic             byte_last;
  logic             val_last;
  logic             tmo_hit;
  logic             send_last;

  // Big-endian assembly: older bytes move up, surplus high bits fall off the value.
  assign acc_next  = (acc << 8) | ACC_W'(rx_data);
  assign byte_last = (bcnt == BCW'(B - 1));
  assign val_last  = (vcnt == VCW'(NVAL - 1));
  assign tmo_hit   = (tcnt == TCW'(TIMEOUT - 1));
  assign send_last = (scnt == SCW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_read    = 1'b0;
    tx_write   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_data_present) begin
          rx_read = 1'b1;
          if (rx_data == CMD_LOAD)    state_next = LOAD;
          else if (rx_data == CMD_GO) state_next = START;
          else                        state_next = RESP;
        end
      end
      LOAD: begin
        if (rx_data_present) begin
          rx_read = 1'b1;
          if (byte_last && val_last) state_next = RESP;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (ws_done)      state_next = SEND;
        else if (tmo_hit) state_next = RESP;
      end
      SEND: begin
        if (!tx_full) begin
          tx_write = 1'b1;
          if (send_last) state_next = IDLE;
        end
      end
      RESP: begin
        if (!tx_full) begin
          tx_write   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      rx_read  = 1'b0;
      tx_write = 1'b0;
    end
  end

  assign tx_data = rst ? 8'h00 : ((state == RESP) ? resp : sum_sh[SUM_W-1 -: 8]);
  assign busy    = !rst && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      bcnt     <= '0;
      vcnt     <= '0;
      tcnt     <= '0;
      scnt     <= '0;
      sum_sh   <= '0;
      resp     <= '0;
      ws_start <= 1'b0;
      x_flat   <= '0;
      w_flat   <= '0;
    end else begin
      ws_start <= (state == START);
      case (state)
        IDLE: begin
          if (rx_read) begin
            acc  <= '0;
            bcnt <= '0;
            vcnt <= '0;
            resp <= RSP_BAD;
          end
        end
        LOAD: begin
          if (rx_read) begin
            acc <= acc_next;
            if (byte_last) begin
              bcnt <= '0;
              vcnt <= vcnt + 1'b1;
              resp <= RSP_OK;
              if (vcnt[0]) w_flat[W*int'(vcnt >> 1) +: W] <= acc_next[W-1:0];
              else         x_flat[W*int'(vcnt >> 1) +: W] <= acc_next[W-1:0];
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        START: tcnt <= '0;
        WAIT: begin
          if (ws_done) begin
            sum_sh <= ws_sum;
            scnt   <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
            resp <= RSP_TMO;
          end
        end
        SEND: begin
          if (tx_write) begin
            sum_sh <= sum_sh << 8;
            scnt   <= scnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_uart_sequencer.sv
`default_nettype none
// tb_perceptron_uart_sequencer: directed scoreboard bench for the UART command sequencer.
module tb_perceptron_uart_sequencer;
  localparam int N        = 8;
  localparam int W        = 18;
  localparam int SUM_W    = 40;
  localparam int TIMEOUT  = 1024;
  localparam int NB       = SUM_W / 8;
  localparam int WS_DELAY = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_data_present;
  logic             rx_read;
  logic [7:0]       tx_data;
  logic             tx_write;
  logic             tx_full;
  logic [W*N-1:0]   x_flat;
  logic [W*N-1:0]   w_flat;
  logic             ws_start;
  logic             ws_done;
  logic [SUM_W-1:0] ws_sum;
  logic             busy;

  always #5 clk = ~clk;

  perceptron_uart_sequencer #(.N(N), .W(W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_present(rx_data_present),
    .rx_read(rx_read), .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .x_flat(x_flat), .w_flat(w_flat), .ws_start(ws_start), .ws_done(ws_done),
    .ws_sum(ws_sum), .busy(busy)
  );

  logic [7:0]       rx_q[$];
  logic [7:0]       exp_q[$];
  int               rx_rd, exp_rd;
  int               total, bad;
  int               cyc, pops, starts, start_cyc, g_cyc, done_cyc, done_lat, last_tx_cyc;
  int               full_hold, done_cd;
  bit               lat_pending, ws_enable, full_arm;
  logic [SUM_W-1:0] model_sum;
  logic [W-1:0]     xv [N];
  logic [W-1:0]     wv [N];
  logic [W*N-1:0]   exp_x, exp_w;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive the FIFO/ws models, let logic settle, then observe the DUT.
  task automatic tick();
    @(negedge clk);
    if (rx_rd < rx_q.size()) begin
      rx_data = rx_q[rx_rd];
      rx_data_present = 1'b1;
    end else begin
      rx_data = 8'h00;
      rx_data_present = 1'b0;
    end
    tx_full = (full_hold > 0);
    if (full_hold > 0) full_hold--;
    ws_done = (done_cd == 1);
    if (done_cd > 0) done_cd--;
    ws_sum = ws_done ? model_sum : {SUM_W{1'b1}};
    #1;
    cyc++;
    if (ws_done) begin
      done_cyc = cyc;
      lat_pending = 1'b1;
    end
    if (rx_read) begin
      pops++;
      if (rx_data == 8'h47 && !busy) g_cyc = cyc;
      rx_rd++;
    end
    if (ws_start) begin
      starts++;
      start_cyc = cyc;
      if (ws_enable) done_cd = WS_DELAY;
    end
    if (tx_write) begin
      last_tx_cyc = cyc;
      if (lat_pending) begin
        done_lat = cyc - done_cyc;
        lat_pending = 1'b0;
      end
      chk("tx_not_while_full", tx_full, 0);
      if (exp_rd < exp_q.size()) begin
        chk("tx_byte", tx_data, exp_q[exp_rd]);
        exp_rd++;
      end else begin
        chk("tx_unexpected", tx_write, 0);
      end
      if (full_arm) begin
        full_hold = 20;
        full_arm = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((exp_rd < exp_q.size() || rx_rd < rx_q.size()) && n < limit) begin
      tick();
      n++;
    end
    chk(tag, (n < limit), 1);
    repeat (3) tick();
  endtask

  task automatic push_sum(input logic [SUM_W-1:0] s);
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
  endtask

  task automatic push_value(input logic [W-1:0] v, input bit junk);
    logic [23:0] b;
    b = 24'(v);
    if (junk) b[23:W] = '1;
    rx_q.push_back(b[23:16]);
    rx_q.push_back(b[15:8]);
    rx_q.push_back(b[7:0]);
  endtask

  task automatic build_expect();
    model_sum = '0;
    for (int j = 0; j < N; j++) begin
      exp_x[W*j +: W] = xv[j];
      exp_w[W*j +: W] = wv[j];
      model_sum += SUM_W'(xv[j]) * SUM_W'(wv[j]);
    end
  endtask

  task automatic load_frame(input bit junk);
    rx_q.push_back(8'h4C);
    for (int k = 0; k < 2 * N; k++) begin
      if (k % 2 == 1) push_value(wv[k/2], junk);
      else            push_value(xv[k/2], junk);
    end
    exp_q.push_back(8'h4B);
  endtask

  initial begin
    rx_rd = 0; exp_rd = 0; total = 0; bad = 0; cyc = 0; pops = 0; starts = 0;
    start_cyc = 0; g_cyc = 0; done_cyc = 0; done_lat = 0; last_tx_cyc = 0;
    full_hold = 0; done_cd = 0; lat_pending = 0; ws_enable = 1; full_arm = 0;
    model_sum = '0; exp_x = '0; exp_w = '0;
    rst = 1'b1; rx_data = 8'h00; rx_data_present = 1'b0; tx_full = 1'b0;
    ws_done = 1'b0; ws_sum = '0;

    repeat (3) tick();
    chk("rst_rx_read", rx_read, 0);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ws_start", ws_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_flat", x_flat, 0);
    chk("rst_w_flat", w_flat, 0);
    rst = 1'b0;
    tick();

    // 'G' on cleared registers: model returns zero
    model_sum = '0;
    starts = 0;
    rx_q.push_back(8'h47);
    push_sum(model_sum);
    drain("t1_drain", 200);
    chk("t1_ws_start_pulses", starts, 1);
    chk("t1_g_to_start", start_cyc - g_cyc, 2);
    chk("t1_done_to_tx", done_lat, 1);
    chk("t1_idle", busy, 0);

    // Load x=10, w=2 everywhere, then run
    for (int j = 0; j < N; j++) begin
      xv[j] = W'(10);
      wv[j] = W'(2);
    end
    build_expect();
    load_frame(1'b0);
    drain("t2_load_drain", 300);
    chk("t2_x_flat", x_flat, exp_x);
    chk("t2_w_flat", w_flat, exp_w);
    rx_q.push_back(8'h47);
    push_sum(model_sum);
    drain("t2_go_drain", 200);

    // Unknown command
    pops = 0;
    starts = 0;
    rx_q.push_back(8'h41);
    exp_q.push_back(8'h3F);
    drain("t3_drain", 100);
    chk("t3_rx_read_once", pops, 1);
    chk("t3_no_start", starts, 0);
    chk("t3_idle", busy, 0);

    // Timeout, then a normal run
    ws_enable = 1'b0;
    starts = 0;
    rx_q.push_back(8'h47);
    exp_q.push_back(8'h54);
    drain("t4_timeout_drain", TIMEOUT + 100);
    chk("t4_start_pulses", starts, 1);
    chk("t4_timeout_cycles", last_tx_cyc - start_cyc, TIMEOUT);
    ws_enable = 1'b1;
    model_sum = 40'h00_000A_BCDE;
    rx_q.push_back(8'h47);
    push_sum(model_sum);
    drain("t4_retry_drain", 200);

    // Back-pressure in the middle of SEND
    model_sum = 40'h12_3456_789A;
    full_arm = 1'b1;
    rx_q.push_back(8'h47);
    push_sum(model_sum);
    drain("t5_drain", 300);
    chk("t5_done_to_tx", done_lat, 1);
    chk("t5_idle", busy, 0);

    // Reset in the middle of a load, then a fresh load with junk high bits
    rx_q.push_back(8'h4C);
    for (int k = 0; k < 10; k++) rx_q.push_back(8'(8'h11 * (k + 1)));
    drain("t6_partial_drain", 100);
    chk("t6_busy_in_load", busy, 1);
    rst = 1'b1;
    repeat (2) tick();
    chk("t6_rst_x_flat", x_flat, 0);
    chk("t6_rst_w_flat", w_flat, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tx_write", tx_write, 0);
    chk("t6_rst_ws_start", ws_start, 0);
    rst = 1'b0;
    tick();
    for (int j = 0; j < N; j++) begin
      xv[j] = W'(32'h2_0000 + j * 32'h1357);
      wv[j] = W'(32'h3_FFFF - j * 32'h2468);
    end
    build_expect();
    load_frame(1'b1);
    drain("t6_load_drain", 300);
    chk("t6_x_flat", x_flat, exp_x);
    chk("t6_w_flat", w_flat, exp_w);
    rx_q.push_back(8'h47);
    push_sum(model_sum);
    drain("t6_go_drain", 200);

    chk("sb_all_consumed", exp_rd, exp_q.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
